// File: rtl/ecg_pkg.sv
// Shared types and constants for the ECG processing chain (filter and R-peak detector).
package ecg_pkg;

   localparam int unsigned DATAWIDTH      = 64;
   localparam int unsigned ORDER          = 32;
   localparam int unsigned COEFFDATAWIDTH = 16;

   typedef logic signed [DATAWIDTH-1:0] sample_t;

   typedef enum logic [1:0] {
      Search,
      Above,
      Refract
   } rpk_state_e;

endpackage

// File: rtl/ecg_thresh_tracker.sv
// Adaptive R-peak threshold: exponential average of committed peak amplitudes, halved and
// floored at MinThresh.
module ecg_thresh_tracker
   import ecg_pkg::*;
#(
   parameter int unsigned DataWidth  = DATAWIDTH,
   parameter int          InitThresh = 1000,
   parameter int          MinThresh  = 200,
   parameter int unsigned AvgShift   = 3
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        update_i,
   input  logic signed [DataWidth-1:0] peak_i,
   output logic signed [DataWidth-1:0] thresh_o
);

   localparam logic signed [DataWidth-1:0] AvgInit = DataWidth'(2 * InitThresh);
   localparam logic signed [DataWidth-1:0] MinVal  = DataWidth'(MinThresh);

   logic signed [DataWidth-1:0] avg_q, avg_d, half;
   logic signed [DataWidth:0]   diff, sum;

   // One extra bit keeps the peak-minus-average difference from overflowing.
   always_comb begin
      diff     = (DataWidth+1)'(peak_i) - (DataWidth+1)'(avg_q);
      sum      = (DataWidth+1)'(avg_q) + (diff >>> AvgShift);
      avg_d    = update_i ? DataWidth'(sum) : avg_q;
      half     = avg_q >>> 1;
      thresh_o = (half >= MinVal) ? half : MinVal;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         avg_q <= AvgInit;
      end else begin
         avg_q <= avg_d;
      end
   end

endmodule

// File: rtl/ecg_rpeak_detector.sv
// R-peak detector: threshold crossing, max tracking, width rejection and refractory period.
// Define ECG_ADAPTIVE_THRESH_EN for the adaptive threshold; otherwise it is fixed at InitThresh.
module ecg_rpeak_detector
   import ecg_pkg::*;
#(
   parameter int unsigned DataWidth      = DATAWIDTH,
   parameter int unsigned CntW           = 16,
   parameter int          InitThresh     = 1000,
   parameter int          MinThresh      = 200,
   parameter int unsigned AvgShift       = 3,
   parameter int unsigned RefractSamples = 72,
   parameter int unsigned MaxWidth       = 40
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic signed [DataWidth-1:0] sample_i,
   input  logic                        sample_valid_i,
   output logic                        peak_valid_o,
   output logic signed [DataWidth-1:0] peak_amp_o,
   output logic [CntW-1:0]             rr_interval_o,
   output logic                        first_peak_o,
   output logic signed [DataWidth-1:0] thresh_o
);

   localparam int unsigned WidthW    = $clog2(MaxWidth + 2);
   localparam int unsigned RefrW     = (RefractSamples > 1) ? $clog2(RefractSamples) : 1;
   localparam logic [WidthW-1:0] WidthReject = WidthW'(MaxWidth + 1);
   localparam logic [RefrW-1:0]  RefrLast    = RefrW'(RefractSamples - 1);
   localparam rpk_state_e AfterPeak = (RefractSamples == 0) ? Search : Refract;

   if (AvgShift >= DataWidth || MinThresh < 0) begin : g_bad_cfg
      $error("ecg_rpeak_detector: invalid AvgShift or MinThresh");
   end

   rpk_state_e                  state_q, state_d;
   logic [CntW-1:0]             idx_q, idx_d, max_idx_q, max_idx_d, prev_idx_q, prev_idx_d;
   logic [CntW-1:0]             rr_q, rr_d;
   logic signed [DataWidth-1:0] max_val_q, max_val_d, peak_amp_q, peak_amp_d;
   logic [WidthW-1:0]           width_q, width_d;
   logic [RefrW-1:0]            refr_q, refr_d;
   logic                        have_prev_q, have_prev_d, first_q, first_d, peak_valid_q;
   logic                        commit, above;
   logic signed [DataWidth-1:0] thresh;

`ifdef ECG_ADAPTIVE_THRESH_EN
   ecg_thresh_tracker #(
      .DataWidth (DataWidth),
      .InitThresh(InitThresh),
      .MinThresh (MinThresh),
      .AvgShift  (AvgShift)
   ) u_thresh (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .update_i(commit),
      .peak_i  (max_val_q),
      .thresh_o(thresh)
   );
`else
   assign thresh = DataWidth'(InitThresh);
`endif

   assign above = (sample_i >= thresh);

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      max_val_d   = max_val_q;
      max_idx_d   = max_idx_q;
      width_d     = width_q;
      refr_d      = refr_q;
      prev_idx_d  = prev_idx_q;
      have_prev_d = have_prev_q;
      peak_amp_d  = peak_amp_q;
      rr_d        = rr_q;
      first_d     = first_q;
      commit      = 1'b0;
      if (sample_valid_i) begin
         idx_d = idx_q + CntW'(1);
         unique case (state_q)
            Search: begin
               if (above) begin
                  state_d   = Above;
                  max_val_d = sample_i;
                  max_idx_d = idx_q;
                  width_d   = WidthW'(1);
               end
            end
            Above: begin
               if (above) begin
                  width_d = width_q + WidthW'(1);
                  if (sample_i > max_val_q) begin
                     max_val_d = sample_i;
                     max_idx_d = idx_q;
                  end
                  // Too wide to be a QRS complex: drop it without touching outputs.
                  if (width_d == WidthReject) begin
                     state_d = AfterPeak;
                     refr_d  = '0;
                  end
               end else begin
                  commit      = 1'b1;
                  state_d     = AfterPeak;
                  refr_d      = '0;
                  peak_amp_d  = max_val_q;
                  rr_d        = have_prev_q ? (max_idx_q - prev_idx_q) : '0;
                  first_d     = !have_prev_q;
                  prev_idx_d  = max_idx_q;
                  have_prev_d = 1'b1;
               end
            end
            Refract: begin
               if (refr_q == RefrLast) begin
                  state_d = Search;
               end
               refr_d = refr_q + RefrW'(1);
            end
            default: state_d = Search;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= Search;
         idx_q        <= '0;
         max_val_q    <= '0;
         max_idx_q    <= '0;
         width_q      <= '0;
         refr_q       <= '0;
         prev_idx_q   <= '0;
         have_prev_q  <= 1'b0;
         peak_amp_q   <= '0;
         rr_q         <= '0;
         first_q      <= 1'b0;
         peak_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         max_val_q    <= max_val_d;
         max_idx_q    <= max_idx_d;
         width_q      <= width_d;
         refr_q       <= refr_d;
         prev_idx_q   <= prev_idx_d;
         have_prev_q  <= have_prev_d;
         peak_amp_q   <= peak_amp_d;
         rr_q         <= rr_d;
         first_q      <= first_d;
         peak_valid_q <= commit;
      end
   end

   assign peak_valid_o  = peak_valid_q;
   assign peak_amp_o    = peak_amp_q;
   assign rr_interval_o = rr_q;
   assign first_peak_o  = first_q;
   assign thresh_o      = thresh;

endmodule
